mips_cpu: RTL and testbench

MIPS_CPU -- requirements
Module: mips_cpu

---
 rtl/mips_cpu.sv | 97 +++++++++
 tb/tb_mips_cpu.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mips_cpu.sv
// mips_cpu: single-cycle MIPS-32 subset with a multiplexed 4-digit seven-segment readout
module mips_cpu #(
  parameter int REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  output logic [6:0] out,
  output logic [3:0] decoderout
);
  logic [31:0] pc, pc4, pc_next, ins, a, b, simm, alu, wd;
  logic [31:0] rf [32];
  logic [31:0] dmem [32];
  logic [REFRESH_BITS-1:0] cnt;
  logic [5:0] op, fn;
  logic [4:0] wa;
  logic is_r, reg_we, mem_we;
  logic [15:0] val;
  logic [1:0] d;
  logic [3:0] nib;
  // program ROM; unlisted words are zero, which decodes as a no-op
  always_comb begin
    case (pc[6:2])
      5'd0: ins = 32'h20010005;
      5'd1: ins = 32'h20020003;
      5'd2: ins = 32'h00221820;
      5'd3: ins = 32'h00222022;
      5'd4: ins = 32'hAC030000;
      5'd5: ins = 32'h8C050000;
      5'd6: ins = 32'h10A30001;
      5'd7: ins = 32'h20060001;
      5'd8: ins = 32'h0041302A;
      5'd9: ins = 32'h08000009;
      default: ins = 32'h0;
    endcase
  end
  assign op = ins[31:26];
  assign fn = ins[5:0];
  assign simm = {{16{ins[15]}}, ins[15:0]};
  assign a = rf[ins[25:21]];
  assign b = rf[ins[20:16]];
  assign is_r = op == 6'h00 && ins[10:6] == 5'd0 &&
                (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
  assign alu = op != 6'h00 ? a + simm :
               fn == 6'h22 ? a - b :
               fn == 6'h24 ? a & b :
               fn == 6'h25 ? a | b :
               fn == 6'h2A ? {31'b0, $signed(a) < $signed(b)} : a + b;
  assign reg_we = is_r || op == 6'h08 || op == 6'h23;
  assign mem_we = op == 6'h2B;
  assign wa = is_r ? ins[15:11] : ins[20:16];
  assign wd = op == 6'h23 ? dmem[alu[6:2]] : alu;
  assign pc4 = pc + 32'd4;
  assign pc_next = (op == 6'h04 && a == b) ? pc4 + {simm[29:0], 2'b00} :
                   op == 6'h02 ? {pc4[31:28], ins[25:0], 2'b00} : pc4;
  // architectural state and refresh counter; $0 is never written so it always reads zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
      cnt <= '0;
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
        dmem[i] <= '0;
      end
    end else begin
      pc <= pc_next;
      cnt <= cnt + REFRESH_BITS'(1);
      if (reg_we && wa != 5'd0) rf[wa] <= wd;
      if (mem_we) dmem[alu[6:2]] <= b;
    end
  end
  assign val = sel ? pc[15:0] : rf[3][15:0];
  assign d = cnt[REFRESH_BITS-1 -: 2];
  assign nib = val[{d, 2'b00} +: 4];
  assign decoderout = ~(4'b0001 << d);
  // hex digit to active-low segment pattern a..g
  always_comb begin
    case (nib)
      4'h0: out = 7'b0000001;
      4'h1: out = 7'b1001111;
      4'h2: out = 7'b0010010;
      4'h3: out = 7'b0000110;
      4'h4: out = 7'b1001100;
      4'h5: out = 7'b0100100;
      4'h6: out = 7'b0100000;
      4'h7: out = 7'b0001111;
      4'h8: out = 7'b0000000;
      4'h9: out = 7'b0000100;
      4'hA: out = 7'b0001000;
      4'hB: out = 7'b1100000;
      4'hC: out = 7'b0110001;
      4'hD: out = 7'b1000010;
      4'hE: out = 7'b0110000;
      default: out = 7'b0111000;
    endcase
  end
endmodule

// File: tb/tb_mips_cpu.sv
// tb_mips_cpu: directed checks of program results, reset behaviour and display scanning
module tb_mips_cpu;
  logic clk = 0, rst = 1, sel = 0;
  logic [6:0] out;
  logic [3:0] decoderout;
  int n_cmp = 0, n_bad = 0, n = 0;
  typedef struct {
    string nm;
    logic sel;
    int d;
    logic [3:0] dec;
    logic [6:0] seg;
  } vec_t;
  vec_t v [8];
  localparam logic [6:0] S0 = 7'b0000001, S2 = 7'b0010010, S4 = 7'b1001100, S6 = 7'b0100000, S8 = 7'b0000000;

  mips_cpu #(.REFRESH_BITS(4)) dut (.clk(clk), .rst(rst), .sel(sel), .out(out), .decoderout(decoderout));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic goto_digit(input int dd, output bit ok);
    ok = 0;
    for (int i = 0; i < 16 && !ok; i++) begin
      if (((n >> 2) & 3) == dd) ok = 1;
      else step(1);
    end
  endtask

  initial begin
    bit ok;
    v[0] = '{"s0_d0", 1'b0, 0, 4'b1110, S8};
    v[1] = '{"s0_d1", 1'b0, 1, 4'b1101, S0};
    v[2] = '{"s0_d2", 1'b0, 2, 4'b1011, S0};
    v[3] = '{"s0_d3", 1'b0, 3, 4'b0111, S0};
    v[4] = '{"s1_d0", 1'b1, 0, 4'b1110, S4};
    v[5] = '{"s1_d1", 1'b1, 1, 4'b1101, S2};
    v[6] = '{"s1_d2", 1'b1, 2, 4'b1011, S0};
    v[7] = '{"s1_d3", 1'b1, 3, 4'b0111, S0};
    // reset held for 5 cycles
    repeat (5) @(posedge clk);
    #1;
    check("rst_pc", dut.pc, 0);
    check("rst_dec_s0", {28'b0, decoderout}, 32'hE);
    check("rst_out_s0", {25'b0, out}, {25'b0, S0});
    sel = 1;
    #1;
    check("rst_dec_s1", {28'b0, decoderout}, 32'hE);
    check("rst_out_s1", {25'b0, out}, {25'b0, S0});
    // first three instructions
    sel = 0;
    rst = 0;
    n = 0;
    step(3);
    check("r1", dut.rf[1], 5);
    check("r2", dut.rf[2], 3);
    check("r3", dut.rf[3], 8);
    check("e3_dec", {28'b0, decoderout}, 32'hE);
    check("e3_out", {25'b0, out}, {25'b0, S8});
    // run to halt
    step(7);
    check("r4", dut.rf[4], 2);
    check("mem0", dut.dmem[0], 8);
    check("r5", dut.rf[5], 8);
    check("r6", dut.rf[6], 1);
    check("pc_halt", dut.pc, 32'h24);
    step(3);
    check("pc_hold", dut.pc, 32'h24);
    // display scan over both sources
    for (int i = 0; i < 8; i++) begin
      sel = v[i].sel;
      goto_digit(v[i].d, ok);
      if (!ok) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: digit %0d not reached", v[i].nm, v[i].d);
      end else begin
        check({v[i].nm, "_dec"}, {28'b0, decoderout}, {28'b0, v[i].dec});
        check({v[i].nm, "_out"}, {25'b0, out}, {25'b0, v[i].seg});
      end
    end
    // digit advances every 4 clocks
    goto_digit(0, ok);
    while (((n + 1) & 3) != 0) step(1);
    check("dwell_d0", {28'b0, decoderout}, 32'hE);
    step(1);
    check("dwell_d1", {28'b0, decoderout}, 32'hD);
    // sel change takes effect without a clock
    goto_digit(0, ok);
    sel = 0;
    #1;
    check("sel_now_0", {25'b0, out}, {25'b0, S8});
    sel = 1;
    #1;
    check("sel_now_1", {25'b0, out}, {25'b0, S4});
    // asynchronous reset mid-program, then restart
    rst = 1;
    #1;
    check("arst_pc", dut.pc, 0);
    check("arst_r6", dut.rf[6], 0);
    check("arst_mem0", dut.dmem[0], 0);
    check("arst_dec", {28'b0, decoderout}, 32'hE);
    @(posedge clk);
    #1;
    rst = 0;
    n = 0;
    step(6);
    check("e6_mem0", dut.dmem[0], 8);
    #2;
    rst = 1;
    #1;
    check("mid_pc", dut.pc, 0);
    check("mid_r3", dut.rf[3], 0);
    @(negedge clk);
    rst = 0;
    n = 0;
    step(2);
    check("re_pc", dut.pc, 8);
    check("re_r3", dut.rf[3], 0);
    check("re_r1", dut.rf[1], 5);
    check("re_r2", dut.rf[2], 3);
    check("re_mem0", dut.dmem[0], 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
